// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module : mem_access_unit_if
//  Desc   : Request, bus-beat and response signals of the load/store unit.
//  Rev    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  bus_req;
    logic                  bus_gnt;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W/8-1:0]   bus_be;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_rvalid;
    logic [DATA_W-1:0]     bus_rdata;

    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_exc;
    logic [4:0]            resp_exccode;

    // Unit side
    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output resp_valid, resp_rdata, resp_exc, resp_exccode
    );

    // Pipeline/bus environment side
    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  resp_valid, resp_rdata, resp_exc, resp_exccode
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module : mem_access_unit
//  Desc   : Sequential load/store unit; lane steering, misalignment split/trap.
//  Rev    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 1,
    parameter int EXC_ADEL         = 4,
    parameter int EXC_ADES         = 5
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mem_access_unit_if.slave    mau
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int SH_W  = OFF_W + 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                store_q;
    logic                unsigned_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                exc_q;
    logic                split_q;

    // Classification of the incoming request
    logic [OFF_W-1:0]    w_in_off;
    logic [3:0]          w_in_n;
    logic [2:0]          w_in_mask;
    logic                w_in_mis;
    logic                w_in_exc;
    logic                w_in_split;

    always_comb begin
        w_in_off = mau.req_addr[OFF_W-1:0];
        w_in_n   = 4'd1 << mau.req_size;
        case (mau.req_size)
            2'd0:    w_in_mask = 3'b000;
            2'd1:    w_in_mask = 3'b001;
            2'd2:    w_in_mask = 3'b011;
            default: w_in_mask = 3'b111;
        endcase
        w_in_mis   = |(mau.req_addr[2:0] & w_in_mask);
        w_in_exc   = ((mau.req_size == 2'd3) && (DATA_W == 32)) ||
                     (w_in_mis && (SPLIT_MISALIGNED == 0));
        w_in_split = (32'(w_in_off) + 32'(w_in_n)) > 32'(NB);
    end

    // Lane steering from the latched request
    logic [OFF_W-1:0]    w_off;
    logic [SH_W-1:0]     w_sh0;
    logic [SH_W-1:0]     w_sh1;
    logic [2*NB-1:0]     w_mask;
    logic [2*NB-1:0]     w_be_full;
    logic [2*DATA_W-1:0] w_wd_full;
    logic [ADDR_W-1:0]   w_base;

    always_comb begin
        w_off = addr_q[OFF_W-1:0];
        w_sh0 = SH_W'({w_off, 3'b000});
        w_sh1 = SH_W'(8 * (32'(NB) - 32'(w_off)));
        case (size_q)
            2'd0:    w_mask = (2*NB)'(8'h01);
            2'd1:    w_mask = (2*NB)'(8'h03);
            2'd2:    w_mask = (2*NB)'(8'h0F);
            default: w_mask = (2*NB)'(8'hFF);
        endcase
        w_be_full = w_mask << w_off;
        w_wd_full = {{DATA_W{1'b0}}, wdata_q} << w_sh0;
        w_base    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Sign/zero extension of the assembled load data
    logic                w_sign;
    int                  w_nbits;
    logic [DATA_W-1:0]   w_ext;

    always_comb begin
        case (size_q)
            2'd0:    begin w_sign = rdata_q[7];        w_nbits = 8;      end
            2'd1:    begin w_sign = rdata_q[15];       w_nbits = 16;     end
            2'd2:    begin w_sign = rdata_q[31];       w_nbits = 32;     end
            default: begin w_sign = rdata_q[DATA_W-1]; w_nbits = DATA_W; end
        endcase
        w_ext = rdata_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= w_nbits) w_ext[i] = w_sign & ~unsigned_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mau.req_valid)  state_d = w_in_exc ? S_RESP : S_REQ0;
            S_REQ0:  if (mau.bus_gnt)    state_d = S_WAIT0;
            S_WAIT0: if (mau.bus_rvalid) state_d = split_q ? S_REQ1 : S_RESP;
            S_REQ1:  if (mau.bus_gnt)    state_d = S_WAIT1;
            S_WAIT1: if (mau.bus_rvalid) state_d = S_RESP;
            S_RESP:                      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            exc_q      <= 1'b0;
            split_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && mau.req_valid) begin
                store_q    <= mau.req_store;
                unsigned_q <= mau.req_unsigned;
                size_q     <= mau.req_size;
                addr_q     <= mau.req_addr;
                wdata_q    <= mau.req_wdata;
                rdata_q    <= '0;
                exc_q      <= w_in_exc;
                split_q    <= w_in_split;
            end
            if (state_q == S_WAIT0 && mau.bus_rvalid)
                rdata_q <= mau.bus_rdata >> w_sh0;
            // Beat 1 supplies the bytes above those kept from beat 0
            if (state_q == S_WAIT1 && mau.bus_rvalid)
                rdata_q <= rdata_q | (mau.bus_rdata << w_sh1);
        end
    end

    always_comb begin
        mau.req_ready    = 1'b0;
        mau.bus_req      = 1'b0;
        mau.bus_we       = 1'b0;
        mau.bus_addr     = '0;
        mau.bus_be       = '0;
        mau.bus_wdata    = '0;
        mau.resp_valid   = 1'b0;
        mau.resp_rdata   = '0;
        mau.resp_exc     = 1'b0;
        mau.resp_exccode = 5'd0;
        case (state_q)
            S_IDLE: mau.req_ready = 1'b1;
            S_REQ0: begin
                mau.bus_req   = 1'b1;
                mau.bus_we    = store_q;
                mau.bus_addr  = w_base;
                mau.bus_be    = w_be_full[NB-1:0];
                mau.bus_wdata = w_wd_full[DATA_W-1:0];
            end
            S_REQ1: begin
                mau.bus_req   = 1'b1;
                mau.bus_we    = store_q;
                mau.bus_addr  = w_base + ADDR_W'(NB);
                mau.bus_be    = w_be_full[2*NB-1:NB];
                mau.bus_wdata = w_wd_full[2*DATA_W-1:DATA_W];
            end
            S_RESP: begin
                mau.resp_valid = 1'b1;
                mau.resp_exc   = exc_q;
                if (exc_q)
                    mau.resp_exccode = store_q ? 5'(EXC_ADES) : 5'(EXC_ADEL);
                else if (!store_q)
                    mau.resp_rdata = w_ext;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module : tb_mem_access_unit
//  Desc   : Directed bench; unit A splits misaligned accesses, unit B traps.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) ifb ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1),
                      .EXC_ADEL(4), .EXC_ADES(5))
        u_dut_a (.clk(clk), .reset(reset), .mau(ifa));

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(0),
                      .EXC_ADEL(4), .EXC_ADES(5))
        u_dut_b (.clk(clk), .reset(reset), .mau(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_access(input string nm, input bit st, input logic [1:0] sz,
                              input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd0, input logic [31:0] rd1, input bit split,
                              input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                              input logic [31:0] exp);
        @(negedge clk);
        chk({nm, ":ready"}, ifa.req_ready, 1);
        ifa.req_valid = 1'b1; ifa.req_store = st; ifa.req_size = sz;
        ifa.req_unsigned = uns; ifa.req_addr = addr; ifa.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        chk({nm, ":beat0"}, {ifa.bus_req, ifa.bus_we, ifa.bus_be, ifa.bus_addr},
            {1'b1, st, be0, a0});
        if (st) chk({nm, ":wdata0"}, ifa.bus_wdata, wd0);
        ifa.bus_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.bus_gnt = 1'b0;
        chk({nm, ":wait0_req"}, ifa.bus_req, 0);
        ifa.bus_rvalid = 1'b1; ifa.bus_rdata = rd0;
        @(posedge clk);
        @(negedge clk);
        ifa.bus_rvalid = 1'b0;
        if (split) begin
            chk({nm, ":beat1"}, {ifa.bus_req, ifa.bus_we, ifa.bus_be, ifa.bus_addr},
                {1'b1, st, be1, a1});
            if (st) chk({nm, ":wdata1"}, ifa.bus_wdata, wd1);
            ifa.bus_gnt = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ifa.bus_gnt = 1'b0;
            ifa.bus_rvalid = 1'b1; ifa.bus_rdata = rd1;
            @(posedge clk);
            @(negedge clk);
            ifa.bus_rvalid = 1'b0;
        end
        chk({nm, ":resp"}, {ifa.resp_valid, ifa.resp_exc, ifa.resp_rdata}, {1'b1, 1'b0, exp});
        @(posedge clk);
        @(negedge clk);
        chk({nm, ":resp_done"}, {ifa.resp_valid, ifa.req_ready}, {1'b0, 1'b1});
    endtask

    task automatic exc_access(input string nm, input bit use_b, input bit st,
                              input logic [1:0] sz, input logic [31:0] addr,
                              input logic [4:0] code);
        @(negedge clk);
        if (use_b) begin
            ifb.req_valid = 1'b1; ifb.req_store = st; ifb.req_size = sz; ifb.req_addr = addr;
        end else begin
            ifa.req_valid = 1'b1; ifa.req_store = st; ifa.req_size = sz; ifa.req_addr = addr;
        end
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
        if (use_b)
            chk({nm, ":resp"}, {ifb.bus_req, ifb.resp_valid, ifb.resp_exc, ifb.resp_exccode,
                                ifb.resp_rdata}, {1'b0, 1'b1, 1'b1, code, 32'h0});
        else
            chk({nm, ":resp"}, {ifa.bus_req, ifa.resp_valid, ifa.resp_exc, ifa.resp_exccode,
                                ifa.resp_rdata}, {1'b0, 1'b1, 1'b1, code, 32'h0});
        @(posedge clk);
        @(negedge clk);
        if (use_b) chk({nm, ":done"}, {ifb.resp_valid, ifb.req_ready}, {1'b0, 1'b1});
        else       chk({nm, ":done"}, {ifa.resp_valid, ifa.req_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        reset = 1'b1;
        ifa.req_valid = 0; ifa.req_store = 0; ifa.req_size = 0; ifa.req_unsigned = 0;
        ifa.req_addr = 0; ifa.req_wdata = 0; ifa.bus_gnt = 0; ifa.bus_rvalid = 0; ifa.bus_rdata = 0;
        ifb.req_valid = 0; ifb.req_store = 0; ifb.req_size = 0; ifb.req_unsigned = 0;
        ifb.req_addr = 0; ifb.req_wdata = 0; ifb.bus_gnt = 0; ifb.bus_rvalid = 0; ifb.bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a", {ifa.req_ready, ifa.bus_req, ifa.resp_valid, ifa.resp_exc}, 4'b1000);
        chk("reset_b", {ifb.req_ready, ifb.bus_req, ifb.resp_valid, ifb.resp_exc}, 4'b1000);
        reset = 1'b0;

        //          name    st sz  u addr          wdata         rd0           rd1          split a0            be0      wd0           a1            be1      wd1           exp
        run_access("lw",    0, 2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0,        0, 32'h100, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hDEADBEEF);
        run_access("lb",    0, 0, 0, 32'h103, 32'h0,        32'h80112233, 32'h0,        0, 32'h100, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hFFFFFF80);
        run_access("lbu",   0, 0, 1, 32'h103, 32'h0,        32'h80112233, 32'h0,        0, 32'h100, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h00000080);
        run_access("lhu",   0, 1, 1, 32'h101, 32'h0,        32'h00ABCD00, 32'h0,        0, 32'h100, 4'b0110, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h0000ABCD);
        run_access("lh",    0, 1, 0, 32'h102, 32'h0,        32'h9ABC0000, 32'h0,        0, 32'h100, 4'b1100, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hFFFF9ABC);
        run_access("lw_sp", 0, 2, 0, 32'h102, 32'h0,        32'h33445566, 32'h77881122, 1, 32'h100, 4'b1100, 32'h0,        32'h104, 4'b0011, 32'h0,        32'h11223344);
        run_access("sw_sp", 1, 2, 0, 32'h102, 32'hAABBCCDD, 32'h0,        32'h0,        1, 32'h100, 4'b1100, 32'hCCDD0000, 32'h104, 4'b0011, 32'h0000AABB, 32'h0);
        run_access("sb",    1, 0, 0, 32'h201, 32'h00000055, 32'h0,        32'h0,        0, 32'h200, 4'b0010, 32'h00005500, 32'h0,   4'b0000, 32'h0,        32'h0);
        run_access("lh_sp", 0, 1, 0, 32'h203, 32'h0,        32'h80000000, 32'h000000FF, 1, 32'h200, 4'b1000, 32'h0,        32'h204, 4'b0001, 32'h0,        32'hFFFFFF80);

        exc_access("sh_trap", 1, 1, 1, 32'h201, 5'd5);
        exc_access("lw_trap", 1, 0, 2, 32'h102, 5'd4);
        exc_access("ld_w32",  0, 0, 3, 32'h108, 5'd4);

        // Grant withheld, then reset lands while the read beat is outstanding
        @(negedge clk);
        ifa.req_valid = 1'b1; ifa.req_store = 1'b0; ifa.req_size = 2'd2; ifa.req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_hold", {ifa.bus_req, ifa.bus_be, ifa.bus_addr}, {1'b1, 4'b1111, 32'h100});
            @(posedge clk);
            @(negedge clk);
        end
        ifa.bus_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.bus_gnt = 1'b0;
        chk("stall_wait0", ifa.bus_req, 0);
        reset = 1'b1;
        #1;
        chk("async_rst", {ifa.bus_req, ifa.req_ready, ifa.resp_valid}, 3'b010);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ifa.bus_rvalid = 1'b1; ifa.bus_rdata = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            ifa.bus_rvalid = 1'b0;
            chk("post_rst_idle", {ifa.bus_req, ifa.req_ready, ifa.resp_valid}, 3'b010);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequential load/store unit between the MEM pipeline stage and the system bus/bridge, replacing purely combinational load-data extraction. It accepts one memory request at a time and generates byte enables and lane-shifted write data. It extracts and sign/zero-extends load data. It is parametrised in data width and handles misaligned accesses, either by splitting them into two bus beats or by raising an address-error exception.

Parameters:
DATA_W, 32, bus/data width in bits; legal values 32 or 64
ADDR_W, 32, address width
SPLIT_MISALIGNED, 1, 1 = split boundary-crossing accesses into two beats; 0 = misaligned raises exception
EXC_ADEL, 4, exception code for a misaligned load
EXC_ADES, 5, exception code for a misaligned store

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_store  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64)
req_unsigned  input  1  load: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data, right-aligned
bus_req  output  1  bus beat request
bus_gnt  input  1  bus accepts beat
bus_we  output  1  beat is a write
bus_addr  output  ADDR_W  beat address, aligned to DATA_W/8
bus_be  output  DATA_W/8  byte enables
bus_wdata  output  DATA_W  lane-shifted write data
bus_rvalid  input  1  beat completion (read data valid, or write acknowledged)
bus_rdata  input  DATA_W  read data
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_W  extended load result (0 for stores and exceptions)
resp_exc  output  1  address-error exception
resp_exccode  output  5  EXC_ADEL or EXC_ADES when resp_exc=1, else 0

Behaviour:
- Let NB = DATA_W/8, off = req_addr mod NB, n = 2^req_size.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Reset (asynchronous, any state): go to IDLE. All outputs go to 0 except req_ready = 1. Captured data clears. An in-flight beat is abandoned and the bus must tolerate this.
- IDLE:
  - On req_valid, latch the request.
  - If the access is misaligned (addr mod n != 0) and SPLIT_MISALIGNED=0, go to RESP with the exception set; no bus activity.
  - Otherwise go to REQ0.
- Split condition: off + n > NB. With size 3 and DATA_W=32, treat the request as misaligned and raise the exception regardless of the parameter.
- REQ0:
  - bus_req=1, bus_addr = addr with the low log2(NB) bits cleared.
  - bus_be = the n-bit mask shifted left by off, truncated to NB bits.
  - bus_wdata = req_wdata << 8*off.
  - Hold all bus outputs stable until bus_gnt, then go to WAIT0.
- WAIT0: bus_req=0. On bus_rvalid, capture bus_rdata >> 8*off. Go to REQ1 if split, else RESP.
- REQ1 (second beat of a split access):
  - bus_addr = beat-0 address + NB.
  - bus_be = low (off+n-NB) bits set.
  - bus_wdata = req_wdata >> 8*(NB-off).
  - On gnt go to WAIT1.
- WAIT1: on bus_rvalid, merge bus_rdata's low bytes above the NB-off bytes captured from beat 0 (little-endian). Go to RESP.
- RESP: resp_valid=1 for exactly one cycle.
  - resp_rdata = the low n bytes, sign- or zero-extended to DATA_W.
  - Go to IDLE.
- Latency, aligned access with gnt and rvalid each one cycle after request: request accepted at edge 0, resp_valid high during cycle 3. A split access adds 2 cycles. A no-split exception responds 1 cycle after accept.
- bus_gnt or bus_rvalid in an unexpected state: ignored.
- req_valid while not in IDLE: ignored, since req_ready=0.

Test Plan:
- DATA_W=32, lw addr 0x100, rdata 0xDEADBEEF, gnt and rvalid immediate -> be=1111, resp_rdata=0xDEADBEEF at cycle 3, exc=0.
- lb signed addr 0x103, rdata 0x80112233 -> be=1000, resp_rdata=0xFFFFFF80; lbu same -> 0x00000080.
- lhu addr 0x101 (no crossing), rdata 0x00ABCD00 -> single beat, be=0110, resp_rdata=0x0000ABCD.
- SPLIT=1, lw addr 0x102, beat0 rdata 0x3344xxxx, beat1 rdata 0xxxxx1122 -> bus_addr 0x100 then 0x104, be 1100 then 0011, resp_rdata=0x11223344. Matching sw 0xAABBCCDD -> wdata 0xCCDD0000 then 0x0000AABB.
- SPLIT=0, sh addr 0x201 -> no bus_req, resp_exc=1, exccode=5, resp_valid 1 cycle after accept.
- bus_gnt held low 5 cycles in REQ0, then reset asserted in WAIT0 -> bus outputs stable while waiting; after reset, immediate IDLE, bus_req=0, req_ready=1, no resp_valid pulse.
